ec_control_unit: RTL and testbench
==================================

Name: ec_control_unit

Overview:
Complete sequencer for the accumulator CPU datapath: state register, next-state logic, opcode decode, and datapath control strobes. It adds an input handshake for the IN instruction, a bounded output handshake for OUT, single-step mode and a retired-instruction counter. It sits between the IR/PC/A datapath and the board I/O (switches/Enter key, display).

Parameters:
OUT_HOLD, 4, maximum cycles an OUT stays in EXEC_OUT without out_ack (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ir_opcode  in  3  IR[7:5], valid from the cycle after FETCH
a_not_zero  in  1  accumulator != 0
in_valid  in  1  Enter pressed, input data valid (level, held until in_ready seen)
out_ack  in  1  display has captured output (single-cycle pulse)
step_mode  in  1  1 = single-step: FETCH waits for step
step  in  1  single-cycle pulse, permits one instruction in step_mode
ir_load  out  1  load IR from memory
pc_load  out  1  load PC (increment or jump target)
jnz_mux  out  1  select IR address field as PC source
in_mux  out  1  select input switches into A
a_load  out  1  load A
out_en  out  1  drive output register
in_ready  out  1  controller waiting for input
state  out  3  current state, debug
halted  out  1  state == HALT
instr_count  out  CNT_W  instructions retired

Behaviour:
- States (encoding fixed): FETCH=000, DECODE=001, IN_WAIT=010, EXEC_IN=011, EXEC_OUT=100, EXEC_DEC=101, EXEC_JNZ=110, HALT=111.
- Reset: state=FETCH, hold counter=0, instr_count=0, step_armed=0. All control outputs are 0 during reset, except those decoded from state FETCH once rst_n deasserts.
- Control outputs are combinational from the registered state (Moore), except pc_load in EXEC_JNZ:
  - FETCH: ir_load=1, pc_load=1.
  - IN_WAIT: in_ready=1.
  - EXEC_IN: in_mux=1, a_load=1.
  - EXEC_OUT: out_en=1.
  - EXEC_DEC: a_load=1.
  - EXEC_JNZ: jnz_mux=1, pc_load=a_not_zero.
  - DECODE and HALT: all strobes 0.
- FETCH leaves to DECODE when step_mode=0 or step_armed=1; otherwise it stalls. While stalled, ir_load and pc_load are forced to 0.
- step_armed: set by a step pulse while in FETCH; cleared on FETCH->DECODE. A step outside FETCH is ignored.
- DECODE next state by opcode:
  - 011 -> IN_WAIT.
  - 100 -> EXEC_OUT.
  - 101 -> EXEC_DEC.
  - 110 -> EXEC_JNZ.
  - 111 -> HALT.
  - 000/001/010 are NOP -> FETCH.
- IN_WAIT -> EXEC_IN on the first cycle in_valid=1; otherwise stay. No timeout.
- EXEC_OUT: hold counter starts at 0 on entry and increments each cycle in the state. Exit to FETCH when out_ack=1 or when counter == OUT_HOLD-1, whichever comes first. out_ack in the entry cycle exits after 1 cycle. Minimum dwell is 1 cycle, maximum OUT_HOLD cycles.
- EXEC_IN, EXEC_DEC, EXEC_JNZ: one cycle each, then FETCH.
- HALT is sticky until rst_n. Inputs are ignored there; instr_count is frozen.
- instr_count increments by 1 (wrapping modulo 2^CNT_W) on every transition into FETCH from DECODE, EXEC_* or IN-path states. Entry into HALT also counts once.
- Cycle cost per instruction: NOP 2; DEC/JNZ 3; OUT 3..2+OUT_HOLD; IN 4+wait.
- Reset asserted mid-instruction (e.g. in IN_WAIT or EXEC_OUT) returns immediately to FETCH and drops all strobes asynchronously.
- Unreachable encodings cannot occur; the default branch -> FETCH.

Test Plan:
- Reset, step_mode=0, opcode 101 constant -> state sequence 000,001,101,000…; a_load high exactly 1 cycle in 3; instr_count=3 after 9 cycles.
- Opcode 011, in_valid raised 5 cycles after IN_WAIT entry -> in_ready high 5 cycles, then one cycle of in_mux=a_load=1, then FETCH.
- Opcode 100, OUT_HOLD=4, no ack -> out_en high exactly 4 cycles. Repeat with out_ack in 2nd cycle -> out_en high 2 cycles.
- Opcode 110 with a_not_zero=1 then 0 -> jnz_mux=1 both times; pc_load=1 in the first EXEC_JNZ only.
- step_mode=1, no step for 10 cycles -> state stays 000, ir_load=0. One step pulse -> exactly one instruction executes, then stall again.
- Opcode 111 -> halted=1 persists for 20 cycles regardless of inputs; instr_count frozen. rst_n low mid-EXEC_OUT -> out_en drops immediately, state=000, instr_count=0.

Source files
------------

// File: rtl/ec_ctrl_if.sv
// Bundle between the accumulator-CPU sequencer and its datapath / board I/O.
// master = the sequencer, slave = datapath and I/O side.
interface ec_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       ir_opcode;
    logic             a_not_zero;
    logic             in_valid;
    logic             out_ack;
    logic             step_mode;
    logic             step;
    logic             ir_load;
    logic             pc_load;
    logic             jnz_mux;
    logic             in_mux;
    logic             a_load;
    logic             out_en;
    logic             in_ready;
    logic [2:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  ir_opcode, a_not_zero, in_valid, out_ack, step_mode, step,
        output ir_load, pc_load, jnz_mux, in_mux, a_load, out_en, in_ready,
               state, halted, instr_count
    );

    modport slave (
        output ir_opcode, a_not_zero, in_valid, out_ack, step_mode, step,
        input  ir_load, pc_load, jnz_mux, in_mux, a_load, out_en, in_ready,
               state, halted, instr_count
    );
endinterface

// File: rtl/ec_control_unit.sv
// Sequencer for the accumulator CPU: fetch/decode/execute FSM with IN/OUT
// handshakes, single-step gating and a retired-instruction counter.
module ec_control_unit #(
    parameter int OUT_HOLD = 4,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ec_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        FETCH    = 3'b000,
        DECODE   = 3'b001,
        IN_WAIT  = 3'b010,
        EXEC_IN  = 3'b011,
        EXEC_OUT = 3'b100,
        EXEC_DEC = 3'b101,
        EXEC_JNZ = 3'b110,
        HALT     = 3'b111
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(OUT_HOLD - 1);

    state_t           state_reg;
    logic [7:0]       hold_reg;
    logic             step_armed_reg;
    logic [CNT_W-1:0] count_reg;
    logic             fetch_go;

    assign fetch_go = !bus.step_mode || step_armed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FETCH;
            hold_reg       <= 8'd0;
            step_armed_reg <= 1'b0;
            count_reg      <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (fetch_go) begin
                        state_reg      <= DECODE;
                        step_armed_reg <= 1'b0;
                    end else if (bus.step) begin
                        step_armed_reg <= 1'b1;
                    end
                end
                DECODE: begin
                    case (bus.ir_opcode)
                        3'b011: state_reg <= IN_WAIT;
                        3'b100: state_reg <= EXEC_OUT;
                        3'b101: state_reg <= EXEC_DEC;
                        3'b110: state_reg <= EXEC_JNZ;
                        3'b111: begin
                            state_reg <= HALT;
                            count_reg <= count_reg + 1'b1;
                        end
                        default: begin
                            state_reg <= FETCH;
                            count_reg <= count_reg + 1'b1;
                        end
                    endcase
                end
                IN_WAIT: begin
                    if (bus.in_valid) state_reg <= EXEC_IN;
                end
                EXEC_OUT: begin
                    // Leave on acknowledge or once the hold budget is spent.
                    if (bus.out_ack || hold_reg == HOLD_LAST) begin
                        state_reg <= FETCH;
                        hold_reg  <= 8'd0;
                        count_reg <= count_reg + 1'b1;
                    end else begin
                        hold_reg <= hold_reg + 8'd1;
                    end
                end
                EXEC_IN, EXEC_DEC, EXEC_JNZ: begin
                    state_reg <= FETCH;
                    count_reg <= count_reg + 1'b1;
                end
                HALT:    state_reg <= HALT;
                default: state_reg <= FETCH;
            endcase
        end
    end

    // Strobes are gated by rst_n so they drop the moment reset asserts.
    always_comb begin
        bus.ir_load  = 1'b0;
        bus.pc_load  = 1'b0;
        bus.jnz_mux  = 1'b0;
        bus.in_mux   = 1'b0;
        bus.a_load   = 1'b0;
        bus.out_en   = 1'b0;
        bus.in_ready = 1'b0;
        if (rst_n) begin
            case (state_reg)
                FETCH: begin
                    bus.ir_load = fetch_go;
                    bus.pc_load = fetch_go;
                end
                IN_WAIT:  bus.in_ready = 1'b1;
                EXEC_IN: begin
                    bus.in_mux = 1'b1;
                    bus.a_load = 1'b1;
                end
                EXEC_OUT: bus.out_en = 1'b1;
                EXEC_DEC: bus.a_load = 1'b1;
                EXEC_JNZ: begin
                    bus.jnz_mux = 1'b1;
                    bus.pc_load = bus.a_not_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.state       = state_reg;
    assign bus.halted      = (state_reg == HALT);
    assign bus.instr_count = count_reg;
endmodule

// File: tb/tb_ec_control_unit.sv
// Instruction-level bench for ec_control_unit: each instruction is expanded
// into its expected cycle trace from the instruction cost rules and compared.
module tb_ec_control_unit;
    localparam int OUT_HOLD = 4;
    localparam int CNT_W    = 16;

    // Expected strobe vector: {ir_load,pc_load,jnz_mux,in_mux,a_load,out_en,in_ready,halted}
    localparam logic [7:0] V_NONE  = 8'b0000_0000;
    localparam logic [7:0] V_FETCH = 8'b1100_0000;
    localparam logic [7:0] V_INW   = 8'b0000_0010;
    localparam logic [7:0] V_EXIN  = 8'b0001_1000;
    localparam logic [7:0] V_OUT   = 8'b0000_0100;
    localparam logic [7:0] V_DEC   = 8'b0000_1000;
    localparam logic [7:0] V_JNZ   = 8'b0010_0000;
    localparam logic [7:0] V_PCLD  = 8'b0100_0000;
    localparam logic [7:0] V_HALT  = 8'b0000_0001;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [CNT_W-1:0] model_cnt;

    ec_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ec_control_unit #(.OUT_HOLD(OUT_HOLD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] obs_vec();
        return {bus.ir_load, bus.pc_load, bus.jnz_mux, bus.in_mux,
                bus.a_load, bus.out_en, bus.in_ready, bus.halted};
    endfunction

    // Called at posedge+1 with inputs already driven; checks, then advances a cycle.
    task automatic do_cycle(input logic [2:0] st, input logic [7:0] vec, input string tag);
        #1;
        chk({tag, "_state"},   32'(bus.state),       32'(st));
        chk({tag, "_strobes"}, 32'(obs_vec()),       32'(vec));
        chk({tag, "_count"},   32'(bus.instr_count), 32'(model_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic anz, input int in_wait,
                             input int ack_at, input logic smode, input int stall);
        int dwell;
        int cyc0;
        cyc0 = 0;
        bus.step_mode = smode;
        bus.ir_opcode = 3'($urandom);
        if (smode) begin
            for (int i = 0; i < stall; i++) begin
                do_cycle(3'd0, V_NONE, "stall");
                cyc0++;
            end
            bus.step = 1'b1;
            do_cycle(3'd0, V_NONE, "step_pulse");
            bus.step = 1'b0;
            cyc0++;
        end
        do_cycle(3'd0, V_FETCH, "fetch");
        bus.ir_opcode = op;
        bus.step      = smode;   // a step outside FETCH must be ignored
        do_cycle(3'd1, V_NONE, "decode");
        bus.step      = 1'b0;
        case (op)
            3'd3: begin
                for (int k = 0; k < in_wait; k++) begin
                    bus.in_valid = (k == in_wait - 1);
                    do_cycle(3'd2, V_INW, "in_wait");
                end
                bus.in_valid = 1'b0;
                do_cycle(3'd3, V_EXIN, "exec_in");
                model_cnt++;
            end
            3'd4: begin
                dwell = (ack_at < 0 || ack_at >= OUT_HOLD) ? OUT_HOLD : ack_at + 1;
                for (int k = 0; k < dwell; k++) begin
                    bus.out_ack = (k == ack_at);
                    do_cycle(3'd4, V_OUT, "exec_out");
                end
                bus.out_ack = 1'b0;
                model_cnt++;
            end
            3'd5: begin
                do_cycle(3'd5, V_DEC, "exec_dec");
                model_cnt++;
            end
            3'd6: begin
                bus.a_not_zero = anz;
                do_cycle(3'd6, anz ? (V_JNZ | V_PCLD) : V_JNZ, "exec_jnz");
                model_cnt++;
            end
            3'd7: begin
                model_cnt++;
                for (int k = 0; k < 20; k++) begin
                    bus.ir_opcode  = 3'($urandom);
                    bus.a_not_zero = 1'($urandom);
                    bus.in_valid   = 1'($urandom);
                    bus.out_ack    = 1'($urandom);
                    bus.step_mode  = 1'($urandom);
                    bus.step       = 1'($urandom);
                    do_cycle(3'd7, V_HALT, "halt");
                end
                bus.in_valid = 1'b0;
                bus.out_ack  = 1'b0;
                bus.step     = 1'b0;
            end
            default: model_cnt++;
        endcase
        $display("instr op=%0d smode=%0d stall_cycles=%0d count=%0d", op, smode, cyc0, model_cnt);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_cnt = '0;
        #1;
        chk("reset_state",   32'(bus.state),       32'd0);
        chk("reset_strobes", 32'(obs_vec()),       32'(V_NONE));
        chk("reset_count",   32'(bus.instr_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_cnt = '0;
        rst_n = 1'b0;
        bus.ir_opcode  = 3'd0;
        bus.a_not_zero = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ack    = 1'b0;
        bus.step_mode  = 1'b0;
        bus.step       = 1'b0;
        #2;
        apply_reset();

        // Directed steps
        for (int i = 0; i < 3; i++) run_instr(3'd5, 1'b0, 1, -1, 1'b0, 0);
        chk("dec_count_after_9", 32'(bus.instr_count), 32'd3);
        run_instr(3'd3, 1'b0, 5, -1, 1'b0, 0);
        run_instr(3'd4, 1'b0, 1, -1, 1'b0, 0);
        run_instr(3'd4, 1'b0, 1,  1, 1'b0, 0);
        run_instr(3'd4, 1'b0, 1,  0, 1'b0, 0);
        run_instr(3'd6, 1'b1, 1, -1, 1'b0, 0);
        run_instr(3'd6, 1'b0, 1, -1, 1'b0, 0);
        run_instr(3'd0, 1'b0, 1, -1, 1'b0, 0);
        run_instr(3'd1, 1'b0, 1, -1, 1'b0, 0);
        run_instr(3'd2, 1'b0, 1, -1, 1'b0, 0);
        run_instr(3'd5, 1'b0, 1, -1, 1'b1, 10);
        run_instr(3'd4, 1'b0, 1, -1, 1'b1, 3);
        run_instr(3'd3, 1'b0, 1, -1, 1'b1, 0);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            run_instr(3'($urandom_range(0, 6)), 1'($urandom), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 6)) - 1, 1'($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 3)));
        end

        // Reset asserted in the middle of an OUT
        bus.step_mode = 1'b0;
        bus.ir_opcode = 3'd4;
        do_cycle(3'd0, V_FETCH, "rmid_fetch");
        do_cycle(3'd1, V_NONE, "rmid_decode");
        do_cycle(3'd4, V_OUT, "rmid_out0");
        #1;
        chk("rmid_out_en_before", 32'(bus.out_en), 32'd1);
        #1;
        rst_n = 1'b0;
        model_cnt = '0;
        #1;
        chk("rmid_state",   32'(bus.state),       32'd0);
        chk("rmid_strobes", 32'(obs_vec()),       32'(V_NONE));
        chk("rmid_count",   32'(bus.instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(3'd5, 1'b0, 1, -1, 1'b0, 0);
        run_instr(3'd0, 1'b0, 1, -1, 1'b0, 0);

        // HALT is sticky with a frozen counter
        run_instr(3'd7, 1'b0, 1, -1, 1'b0, 0);
        apply_reset();
        run_instr(3'd6, 1'b1, 1, -1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
